// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch. Consumes the 1 Hz tick from the programmable timer,
// drives the timer's load/enable, and runs a four-state button FSM
// (IDLE/RUN/PAUSE/LAP). The four BCD digits feed the 7-segment mux.
module stopwatch_bcd #(
  parameter logic [3:0] MIN_TENS_MAX = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       timer_load,
  output logic       timer_en,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       lap_active,
  output logic       rollover
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  state_t    state;
  bcd_time_t count, count_next, snapshot, shown;
  logic      prev_ss, prev_lap, prev_clr;
  logic      press_ss, press_lap, press_clr;
  logic      do_ss, do_lap, do_clr;
  logic      advance, wrap;

  // Rising-edge press detection with clr > ss > lap priority; a lower-priority
  // press in the same cycle is dropped even when the winner is ignored.
  always_comb begin
    press_ss  = btn_ss  & ~prev_ss;
    press_lap = btn_lap & ~prev_lap;
    press_clr = btn_clr & ~prev_clr;
    do_clr    = press_clr;
    do_ss     = press_ss  & ~press_clr;
    do_lap    = press_lap & ~press_clr & ~press_ss;
  end

  // Next count: BCD ripple increment, one second per tick while counting.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    count_next = count;
    wrap       = 1'b0;
    advance    = ((state == RUN) || (state == LAP)) && tick;
    if (advance) begin
      if (count.sec_ones != 4'd9) begin
        count_next.sec_ones = count.sec_ones + 4'd1;
      end else begin
        count_next.sec_ones = 4'd0;
        if (count.sec_tens != 4'd5) begin
          count_next.sec_tens = count.sec_tens + 4'd1;
        end else begin
          count_next.sec_tens = 4'd0;
          if (count.min_ones != 4'd9) begin
            count_next.min_ones = count.min_ones + 4'd1;
          end else begin
            count_next.min_ones = 4'd0;
            if (count.min_tens != MIN_TENS_MAX) begin
              count_next.min_tens = count.min_tens + 4'd1;
            end else begin
              count_next.min_tens = 4'd0;
              wrap                = 1'b1;
            end
          end
        end
      end
    end
  end

  // Button FSM, live count, lap snapshot and registered rollover pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      snapshot <= '0;
      prev_ss  <= 1'b0;
      prev_lap <= 1'b0;
      prev_clr <= 1'b0;
      rollover <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      prev_ss  <= btn_ss;
      prev_lap <= btn_lap;
      prev_clr <= btn_clr;
      rollover <= wrap;
      count    <= count_next;
      case (state)
        IDLE: begin
          if (do_ss) state <= RUN;
        end
        RUN: begin
          if (do_ss) begin
            state <= PAUSE;
          end else if (do_lap) begin
            state    <= LAP;
            snapshot <= count_next;
          end
        end
        PAUSE: begin
          if (do_ss) begin
            state <= RUN;
          end else if (do_clr) begin
            state <= IDLE;
            count <= '0;
          end
        end
        LAP: begin
          if (do_lap)     state <= RUN;
          else if (do_ss) state <= PAUSE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs: timer_load fires in the same cycle as the IDLE->RUN press so the
  // timer restarts its phase on that edge; the display freezes in LAP.
  always_comb begin
    timer_load = (state == IDLE) && do_ss;
    timer_en   = (state == RUN) || (state == LAP);
    lap_active = (state == LAP);
    shown      = (state == LAP) ? snapshot : count;
    sec_ones   = shown.sec_ones;
    sec_tens   = shown.sec_tens;
    min_ones   = shown.min_ones;
    min_tens   = shown.min_tens;
  end

endmodule
